// File: rtl/x9_pkg.sv
// Shared run-state encoding and default sizing for the X9 program-run controller.
// Types and constants only; no logic.
package x9_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } run_state_t;

    localparam int D_DEF         = 12;
    localparam int LW_DEF        = 5;
    localparam int HALT_ADDR_DEF = 128;
    localparam int CW_DEF        = 16;
    localparam int MAX_CYC_DEF   = 4000;

endpackage

// File: rtl/target_lut.sv
// Branch-target table: 2^LW x D registers, combinational read, one-cycle write latency.
// Writes are dropped unless wr_ok is high; no backpressure.
module target_lut #(
    parameter int D  = 12,
    parameter int LW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_ok,
    input  logic          we,
    input  logic [LW-1:0] waddr,
    input  logic [D-1:0]  wdata,
    input  logic [LW-1:0] raddr,
    output logic [D-1:0]  rdata
);

    localparam int N = 1 << LW;

    logic [D-1:0] mem [N];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else if (we && wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/x9_run_ctrl.sv
// Program-run controller: PC, jump-target LUT, ALU flag registers and req/done handshake.
// Start and step take one edge each; stall freezes all run state, req drop aborts.
module x9_run_ctrl
    import x9_pkg::*;
#(
    parameter int D         = D_DEF,
    parameter int LW        = LW_DEF,
    parameter int HALT_ADDR = HALT_ADDR_DEF,
    parameter int CW        = CW_DEF,
    parameter int MAX_CYC   = MAX_CYC_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          done,
    output logic          busy,
    output logic          err,
    output logic [D-1:0]  prog_ctr,
    input  logic          stall,
    input  logic          reljump_en,
    input  logic          absjump_en,
    input  logic [LW-1:0] lut_idx,
    input  logic          lut_we,
    input  logic [LW-1:0] lut_waddr,
    input  logic [D-1:0]  lut_wdata,
    input  logic          pari,
    input  logic          zero,
    input  logic          sc_o,
    input  logic          sc_en,
    input  logic          sc_clr,
    output logic          pariQ,
    output logic          zeroQ,
    output logic          sc_q,
    output logic [CW-1:0] cycle_cnt
);

    localparam logic [D-1:0] HALT_PC = D'(HALT_ADDR);
    localparam logic [CW:0]  CYC_LIM = (CW + 1)'(MAX_CYC);

    run_state_t   state_q, state_d;
    logic         start, step;
    logic [D-1:0] lut_rd, next_pc;
    logic [CW:0]  cnt_inc;
    logic         halt_hit, tmo_hit;

    target_lut #(
        .D  (D),
        .LW (LW)
    ) u_lut (
        .clk   (clk),
        .reset (reset),
        .wr_ok (state_q == IDLE),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (lut_idx),
        .rdata (lut_rd)
    );

    // Adding the raw D-bit entry equals adding it sign-extended, mod 2^D.
    always_comb begin
        next_pc = prog_ctr + D'(1);
        if (absjump_en) begin
            next_pc = lut_rd;
        end else if (reljump_en) begin
            next_pc = prog_ctr + lut_rd;
        end
    end

    assign cnt_inc  = {1'b0, cycle_cnt} + (CW + 1)'(1);
    assign halt_hit = (next_pc == HALT_PC);
    assign tmo_hit  = (cnt_inc == CYC_LIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (!stall) begin
                    step = 1'b1;
                    if (halt_hit || tmo_hit) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prog_ctr  <= '0;
            cycle_cnt <= '0;
            err       <= 1'b0;
            pariQ     <= 1'b0;
            zeroQ     <= 1'b0;
            sc_q      <= 1'b0;
        end else if (start) begin
            prog_ctr  <= '0;
            cycle_cnt <= '0;
            err       <= 1'b0;
            pariQ     <= 1'b0;
            zeroQ     <= 1'b0;
            sc_q      <= 1'b0;
        end else if (step) begin
            prog_ctr  <= next_pc;
            cycle_cnt <= (&cycle_cnt) ? cycle_cnt : cnt_inc[CW-1:0];
            // A halt on the budget edge still counts as a normal finish.
            if (tmo_hit && !halt_hit) begin
                err <= 1'b1;
            end
            pariQ <= pari;
            zeroQ <= zero;
            if (sc_clr) begin
                sc_q <= 1'b0;
            end else if (sc_en) begin
                sc_q <= sc_o;
            end
        end
    end

endmodule

// File: tb/tb_x9_run_ctrl.sv
// Directed bench for x9_run_ctrl: default instance plus a MAX_CYC=50 instance on shared inputs.
module tb_x9_run_ctrl;

    logic        clk;
    logic        reset;
    logic        req;
    logic        stall;
    logic        reljump_en;
    logic        absjump_en;
    logic [4:0]  lut_idx;
    logic        lut_we;
    logic [4:0]  lut_waddr;
    logic [11:0] lut_wdata;
    logic        pari, zero, sc_o, sc_en, sc_clr;

    logic        done, busy, err, pariQ, zeroQ, sc_q;
    logic [11:0] prog_ctr;
    logic [15:0] cycle_cnt;

    logic        done2, busy2, err2, pariQ2, zeroQ2, sc_q2;
    logic [11:0] prog_ctr2;
    logic [15:0] cycle_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    x9_run_ctrl #(.D(12), .LW(5), .HALT_ADDR(128), .CW(16), .MAX_CYC(4000)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done), .busy(busy), .err(err),
        .prog_ctr(prog_ctr), .stall(stall), .reljump_en(reljump_en), .absjump_en(absjump_en),
        .lut_idx(lut_idx), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .pari(pari), .zero(zero), .sc_o(sc_o), .sc_en(sc_en), .sc_clr(sc_clr),
        .pariQ(pariQ), .zeroQ(zeroQ), .sc_q(sc_q), .cycle_cnt(cycle_cnt)
    );

    x9_run_ctrl #(.D(12), .LW(5), .HALT_ADDR(128), .CW(16), .MAX_CYC(50)) dut_tmo (
        .clk(clk), .reset(reset), .req(req), .done(done2), .busy(busy2), .err(err2),
        .prog_ctr(prog_ctr2), .stall(stall), .reljump_en(reljump_en), .absjump_en(absjump_en),
        .lut_idx(lut_idx), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .pari(pari), .zero(zero), .sc_o(sc_o), .sc_en(sc_en), .sc_clr(sc_clr),
        .pariQ(pariQ2), .zeroQ(zeroQ2), .sc_q(sc_q2), .cycle_cnt(cycle_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic lut_write(input logic [4:0] a, input logic [11:0] d);
        lut_we    = 1'b1;
        lut_waddr = a;
        lut_wdata = d;
        tick(1);
        lut_we    = 1'b0;
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; stall = 1'b0; reljump_en = 1'b0; absjump_en = 1'b0;
        lut_idx = '0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
        pari = 1'b0; zero = 1'b0; sc_o = 1'b0; sc_en = 1'b0; sc_clr = 1'b0;
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_pc", prog_ctr, 0);
        check("rst_cnt", cycle_cnt, 0);
        check("rst_flags", {pariQ, zeroQ, sc_q}, 0);
        #3 reset = 1'b1;
        tick(1);

        // Straight line to the halt address.
        req = 1'b1;
        tick(1);
        check("start_busy", busy, 1);
        check("start_pc", prog_ctr, 0);
        tick(127);
        check("sl_pc127", prog_ctr, 127);
        check("sl_done_before", done, 0);
        tick(1);
        check("sl_pc128", prog_ctr, 128);
        check("sl_done", done, 1);
        check("sl_busy", busy, 0);
        check("sl_cnt", cycle_cnt, 128);
        check("sl_err", err, 0);
        tick(2);
        check("sl_done_hold", done, 1);
        check("sl_pc_hold", prog_ctr, 128);
        req = 1'b0;
        tick(1);
        check("sl_done_fall", done, 0);

        // Jumps.
        lut_write(5'd3, 12'h050);
        lut_write(5'd4, 12'hFFE);
        lut_write(5'd6, 12'hFFF);
        lut_write(5'd7, 12'h080);
        req = 1'b1;
        tick(1);
        reljump_en = 1'b1; lut_idx = 5'd6;
        tick(1);
        check("rel_m1_from0", prog_ctr, 12'hFFF);
        reljump_en = 1'b0;
        tick(1);
        check("pc_wrap", prog_ctr, 0);
        check("wrap_err", err, 0);
        tick(10);
        check("pc10", prog_ctr, 10);
        reljump_en = 1'b1; lut_idx = 5'd4;
        tick(1);
        check("rel_m2", prog_ctr, 8);
        reljump_en = 1'b0; absjump_en = 1'b1; lut_idx = 5'd3;
        tick(1);
        check("abs_jump", prog_ctr, 12'h050);
        reljump_en = 1'b1;
        lut_we = 1'b1; lut_waddr = 5'd3; lut_wdata = 12'h123;
        tick(1);
        lut_we = 1'b0;
        check("abs_over_rel", prog_ctr, 12'h050);
        reljump_en = 1'b0; absjump_en = 1'b0;
        tick(1);
        check("plain_step", prog_ctr, 12'h051);
        absjump_en = 1'b1;
        tick(1);
        check("lut_run_wr_ignored", prog_ctr, 12'h050);
        check("jump_cnt", cycle_cnt, 17);
        lut_idx = 5'd7;
        tick(1);
        check("halt_jump_pc", prog_ctr, 12'h080);
        check("halt_jump_done", done, 1);
        check("halt_jump_cnt", cycle_cnt, 18);
        absjump_en = 1'b0;
        req = 1'b0;
        tick(1);

        // Stall and flags.
        req = 1'b1;
        tick(1);
        tick(20);
        check("st_pc20", prog_ctr, 20);
        stall = 1'b1; pari = 1'b1; zero = 1'b1; sc_en = 1'b1; sc_o = 1'b1;
        tick(5);
        check("st_pc_frozen", prog_ctr, 20);
        check("st_cnt_frozen", cycle_cnt, 20);
        check("st_flags_frozen", {pariQ, zeroQ, sc_q}, 0);
        check("st_busy", busy, 1);
        stall = 1'b0;
        tick(1);
        check("st_resume_pc", prog_ctr, 21);
        check("st_resume_cnt", cycle_cnt, 21);
        check("flags_follow", {pariQ, zeroQ, sc_q}, 3'b111);
        sc_clr = 1'b1; pari = 1'b0;
        tick(1);
        check("sc_clr_wins", sc_q, 0);
        check("pari_follow", pariQ, 0);
        check("zero_follow", zeroQ, 1);
        sc_clr = 1'b0; zero = 1'b0;
        tick(1);
        check("sc_en_load", sc_q, 1);
        check("zero_follow0", zeroQ, 0);
        sc_en = 1'b0; sc_o = 1'b0;
        tick(1);
        check("sc_hold", sc_q, 1);
        tick(16);
        check("ab_pc40", prog_ctr, 40);
        req = 1'b0;
        tick(1);
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        check("ab_pc_kept", prog_ctr, 40);
        tick(1);
        check("ab_no_done", done, 0);

        // Timeout on the MAX_CYC=50 instance with a zero-offset self-loop.
        req = 1'b1; reljump_en = 1'b1; lut_idx = 5'd5;
        tick(1);
        tick(49);
        check("to_cnt49", cycle_cnt2, 49);
        check("to_not_done", done2, 0);
        check("to_pc_loop", prog_ctr2, 0);
        tick(1);
        check("to_done", done2, 1);
        check("to_err", err2, 1);
        check("to_cnt50", cycle_cnt2, 50);
        check("to_other_busy", busy, 1);
        req = 1'b0;
        tick(1);
        check("to_err_held_idle", err2, 1);
        check("to_done_fall", done2, 0);
        req = 1'b1;
        tick(1);
        check("to_err_cleared", err2, 0);
        check("to_rerun_busy", busy2, 1);
        reljump_en = 1'b0;
        req = 1'b0;
        tick(1);

        // Asynchronous reset mid-run.
        req = 1'b1; pari = 1'b1;
        tick(6);
        check("rr_pc", prog_ctr, 5);
        check("rr_pariq", pariQ, 1);
        #2 reset = 1'b0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_pc", prog_ctr, 0);
        check("ar_cnt", cycle_cnt, 0);
        check("ar_flags", {pariQ, zeroQ, sc_q}, 0);
        check("ar_done", done, 0);
        #3 reset = 1'b1;
        pari = 1'b0;
        tick(1);
        tick(1);
        check("ar_restart", busy, 1);
        absjump_en = 1'b1; lut_idx = 5'd3;
        tick(1);
        check("ar_lut_cleared", prog_ctr, 0);
        absjump_en = 1'b0; req = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/x9_run_ctrl.md
# x9_run_ctrl

Parametrised program-run controller for the X9 core. It owns the program counter, the branch-target lookup table and the registered ALU flags, and wraps them in a level-sensitive `req`/`done` run handshake with halt-address and cycle-budget termination. It sits between the instruction ROM and the control decoder and replaces the fixed PC, fixed LUT and `prog_ctr == 128` done logic with one sequential unit. Beyond the old logic it adds a writable LUT, stall support, abort on `req` drop, a run-cycle counter and a timeout error.

## Interface
- `D`, 12: program counter width.
- `LW`, 5: LUT index width; the LUT has 2^LW entries of D bits each.
- `HALT_ADDR`, 128: a PC value equal to this ends the run normally.
- `CW`, 16: width of the cycle counter.
- `MAX_CYC`, 4000: cycle budget; reaching it ends the run with `err`.
- `clk` in 1: clock.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `req` in 1: run request, level-sensitive.
- `done` out 1: run finished.
- `busy` out 1: run in progress.
- `err` out 1: last run ended by timeout.
- `prog_ctr` out D: current program counter.
- `stall` in 1: hold PC, flags and counter this cycle.
- `reljump_en` in 1: relative jump, next PC is PC + signed target.
- `absjump_en` in 1: absolute jump, next PC is target.
- `lut_idx` in LW: selects the jump target.
- `lut_we` in 1: LUT write strobe.
- `lut_waddr` in LW: LUT write address.
- `lut_wdata` in D: LUT write data.
- `pari` in 1: raw parity flag.
- `zero` in 1: raw zero flag.
- `sc_o` in 1: raw shift/carry out.
- `sc_en` in 1: shift/carry register enable.
- `sc_clr` in 1: shift/carry register clear.
- `pariQ` out 1: registered parity flag.
- `zeroQ` out 1: registered zero flag.
- `sc_q` out 1: registered shift/carry, feeds the ALU `sc_i`.
- `cycle_cnt` out CW: non-stalled RUN cycles in the current or last run.

## Operation
- FSM has three states: IDLE, RUN, DONE. Outputs: `busy` = (state==RUN); `done` = (state==DONE).
- IDLE, `req`=1: go to RUN. Load `prog_ctr`=0, `cycle_cnt`=0, `err`=0, all three flags 0.
- RUN, `req`=0: abort to IDLE. `done` is not raised. PC, counter and flags keep their values.
- RUN, `stall`=1: no state changes.
- RUN, non-stalled cycle:
  - `next_pc` is `lut[lut_idx]` if `absjump_en`=1; else PC + `lut[lut_idx]` sign-extended, mod 2^D, if `reljump_en`=1; else PC+1 mod 2^D.
  - `absjump_en` has priority over `reljump_en`.
  - `cycle_cnt` increments by 1 and saturates at 2^CW−1.
- Halt: if `next_pc`==HALT_ADDR, PC loads HALT_ADDR and the state goes to DONE on the same edge.
- Timeout: if `cycle_cnt`+1 == MAX_CYC and there is no halt, go to DONE with `err`=1. PC still advances. Halt has priority over timeout on the same edge.
- DONE: hold everything while `req`=1. On `req`=0, go to IDLE; `done` falls on that edge. `err` stays valid until the next run starts.
- Flags update only in non-stalled RUN cycles:
  - `pariQ`<=`pari`, `zeroQ`<=`zero`.
  - `sc_q` is cleared by `sc_clr`, else loads `sc_o` when `sc_en`=1. `sc_clr` wins over `sc_en`.
- LUT:
  - Read is combinational.
  - Writes take effect only in IDLE and are silently ignored in RUN or DONE. A write is visible on the next cycle.
  - All entries clear to 0 on reset.

## Timing
- Reset (`reset`=0, asynchronous) forces: state IDLE, `prog_ctr`=0, `cycle_cnt`=0, `done`=`busy`=`err`=0, `pariQ`=`zeroQ`=`sc_q`=0, LUT all 0.
- Reset asserted mid-run aborts immediately; no `done` pulse.
- Start latency: `req` high at edge N gives `busy`=1 and PC=0 after N. The first instruction executes in cycle N+1.
- Every output is registered, except `busy` and `done`, which decode the state register.
- A halt jump committed at edge M gives `done`=1 and `prog_ctr`=HALT_ADDR in cycle M+1.
- PC wrap: 2^D−1 +1 = 0, with no error raised.
- A relative jump of −1 from PC 0 gives 2^D−1.
- `req` re-asserted in the same cycle DONE→IDLE occurs starts the next run one cycle later. IDLE always lasts at least one cycle.

## Structure
- Package `x9_pkg` holds:
  - the enum `run_state_t` {IDLE, RUN, DONE};
  - default constants for D, LW, HALT_ADDR, CW and MAX_CYC.
- Sub-module `target_lut`: 2^LW×D register array with async clear, write-enable gated by `wr_ok`, and a combinational read port.
- FSM, PC, counter and flag registers stay in the top of `x9_run_ctrl`.

## Test plan
- Straight line, with D=12, HALT_ADDR=128 and `req` held high:
  - `done` rises in the cycle after PC 127 steps to 128;
  - `cycle_cnt`=128 and `err`=0;
  - dropping `req` clears `done` on the next cycle.
- Jumps, with lut[3]=0x050 and lut[4]=0xFFE (−2), from PC=10:
  - absolute jump gives PC=0x050;
  - relative jump gives PC=8;
  - both asserted gives 0x050;
  - a LUT write during RUN leaves lut[3] unchanged.
- Stall, with `stall`=1 for 5 cycles at PC=20: PC, `cycle_cnt` and flags are frozen, then resume at 21.
- Timeout, with MAX_CYC=50 and a self-loop (rel jump 0): `done`=1 and `err`=1 after exactly 50 cycles. A new `req` clears `err`.
- Flags:
  - `sc_clr` and `sc_en` both high with `sc_o`=1 gives `sc_q`=0;
  - `sc_en` only gives `sc_q`=1;
  - `pariQ`/`zeroQ` follow the inputs one cycle late.
- Abort and reset:
  - `req` dropped at PC=40 returns to IDLE with no `done`;
  - asynchronous `reset` low mid-run clears all outputs and LUT entries without waiting for a clock edge.
